// File: rtl/multi_cycle_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB slice first,
// and reports the full-width sum, carry out and signed overflow on a done pulse.
module multi_cycle_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       fsm_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("multi_cycle_adder: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] a, b, acc, next_acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] sa, sb;
    logic [DIGIT:0]   slice_sum;
    logic             last;
    logic             load;

    // Handshake: start is a request taken only in IDLE or DONE (busy=0); an
    // accepted start captures x/y/cin/sub, and exactly one done pulse follows
    // N+1 cycles later unless rst intervenes. start seen while busy is dropped.
    always_comb begin
        next_state = state;
        sa         = a[int'(cnt)*DIGIT +: DIGIT];
        sb         = b[int'(cnt)*DIGIT +: DIGIT];
        slice_sum  = {1'b0, sa} + {1'b0, sb} + {{DIGIT{1'b0}}, carry};
        next_acc   = acc;
        next_acc[int'(cnt)*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
        last       = (cnt == CW'(N - 1));
        load       = start && (state == IDLE || state == DONE);
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
        busy      = (state == RUN);
        done      = (state == DONE);
        fsm_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                a     <= x;
                b     <= sub ? ~y : y;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
                acc   <= '0;
            end else if (state == RUN) begin
                acc   <= next_acc;
                carry <= slice_sum[DIGIT];
                cnt   <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    out  <= next_acc;
                    cout <= slice_sum[DIGIT];
                    // a^b^sum at the MSB recovers the carry into it, wherever it sits in the slice
                    ovf  <= slice_sum[DIGIT] ^ next_acc[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboarded bench for multi_cycle_adder: three WIDTH=4 instances (DIGIT 1,2,4)
// share stimulus, plus one WIDTH=8 DIGIT=4 instance with its own stimulus.
module tb_multi_cycle_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst = 1'b1;
    logic       start = 1'b0, cin = 1'b0, sub = 1'b0;
    logic [3:0] x = '0, y = '0;
    logic       start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] x8 = '0, y8 = '0;

    logic       busy1, done1, cout1, ovf1, busy2, done2, cout2, ovf2;
    logic       busy4, done4, cout4, ovf4, busy8, done8, cout8, ovf8;
    logic [3:0] out1, out2, out4;
    logic [7:0] out8;
    logic [1:0] st1, st2, st4, st8;

    multi_cycle_adder #(.WIDTH(4), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .cin(cin), .sub(sub), .busy(busy1), .done(done1), .out(out1), .cout(cout1), .ovf(ovf1), .fsm_state(st1));
    multi_cycle_adder #(.WIDTH(4), .DIGIT(2)) dut2 (.clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .cin(cin), .sub(sub), .busy(busy2), .done(done2), .out(out2), .cout(cout2), .ovf(ovf2), .fsm_state(st2));
    multi_cycle_adder #(.WIDTH(4), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .start(start), .x(x), .y(y),
        .cin(cin), .sub(sub), .busy(busy4), .done(done4), .out(out4), .cout(cout4), .ovf(ovf4), .fsm_state(st4));
    multi_cycle_adder #(.WIDTH(8), .DIGIT(4)) dut8 (.clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
        .cin(cin8), .sub(sub8), .busy(busy8), .done(done8), .out(out8), .cout(cout8), .ovf(ovf8), .fsm_state(st8));

    int tests = 0;
    int fails = 0;

    // Entry layout: {done cycle[15:0], cout, ovf, out[7:0]}
    logic [25:0] q1[$], q2[$], q4[$], q8[$];
    logic [25:0] e1, e2, e4, e8;
    int          bc1 = 0, bc2 = 0, bc4 = 0;
    logic [3:0]  held1 = '0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [9:0] ref4(input logic [3:0] xa, input logic [3:0] ya, input logic ci, input logic su);
        logic [3:0] bb;
        logic [4:0] s;
        logic       v;
        bb = su ? ~ya : ya;
        s  = {1'b0, xa} + {1'b0, bb} + {4'b0, (su ? 1'b1 : ci)};
        v  = (xa[3] == bb[3]) && (s[3] != xa[3]);
        return {s[4], v, 4'b0, s[3:0]};
    endfunction

    task automatic push4(input int c, input logic [9:0] e, input bit p1, input bit p2, input bit p4);
        if (p1) q1.push_back({16'(c + 5), e});
        if (p2) q2.push_back({16'(c + 3), e});
        if (p4) q4.push_back({16'(c + 2), e});
    endtask

    task automatic w4_issue(input logic [3:0] xa, input logic [3:0] ya, input logic ci, input logic su,
                            input logic [9:0] e);
        @(posedge clk) #1;
        x = xa; y = ya; cin = ci; sub = su; start = 1'b1;
        push4(cyc, e, 1'b1, 1'b1, 1'b1);
        @(posedge clk) #1;
        start = 1'b0;
        x = 4'($urandom); y = 4'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        repeat (3) @(posedge clk);
    endtask

    task automatic w8_issue(input logic [7:0] xa, input logic [7:0] ya, input logic ci, input logic su,
                            input logic [9:0] e);
        @(posedge clk) #1;
        x8 = xa; y8 = ya; cin8 = ci; sub8 = su; start8 = 1'b1;
        q8.push_back({16'(cyc + 3), e});
        @(posedge clk) #1;
        start8 = 1'b0;
        x8 = 8'($urandom); y8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        repeat (2) @(posedge clk);
    endtask

    task automatic chk_zero(input string tag, input logic [7:0] o, input logic c, input logic v,
                            input logic b, input logic d);
        chk({tag, "_rst_out"}, o, 0);
        chk({tag, "_rst_flags"}, {c, v, b, d}, 0);
    endtask

    // Monitors: pop and compare whenever an instance pulses done
    always @(negedge clk) begin
        if (cyc > 4) begin
            if (!done1) chk("d1_out_hold", out1, held1);
            else held1 = out1;
            if (rst) held1 = '0;
        end
        if (done1) begin
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL d1_unexpected_done out=%0h at cycle %0d, required no done", out1, cyc);
            end else begin
                e1 = q1.pop_front();
                chk("d1_out", out1, e1[3:0]); chk("d1_cout", cout1, e1[9]); chk("d1_ovf", ovf1, e1[8]);
                chk("d1_latency", cyc, e1[25:10]); chk("d1_busy_cycles", bc1, 4);
            end
            bc1 = 0;
        end else if (busy1) bc1++;
        else bc1 = 0;
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                tests++; fails++;
                $display("FAIL d2_unexpected_done out=%0h at cycle %0d, required no done", out2, cyc);
            end else begin
                e2 = q2.pop_front();
                chk("d2_out", out2, e2[3:0]); chk("d2_cout", cout2, e2[9]); chk("d2_ovf", ovf2, e2[8]);
                chk("d2_latency", cyc, e2[25:10]); chk("d2_busy_cycles", bc2, 2);
            end
            bc2 = 0;
        end else if (busy2) bc2++;
        else bc2 = 0;
    end

    always @(negedge clk) begin
        if (done4) begin
            if (q4.size() == 0) begin
                tests++; fails++;
                $display("FAIL d4_unexpected_done out=%0h at cycle %0d, required no done", out4, cyc);
            end else begin
                e4 = q4.pop_front();
                chk("d4_out", out4, e4[3:0]); chk("d4_cout", cout4, e4[9]); chk("d4_ovf", ovf4, e4[8]);
                chk("d4_latency", cyc, e4[25:10]); chk("d4_busy_cycles", bc4, 1);
            end
            bc4 = 0;
        end else if (busy4) bc4++;
        else bc4 = 0;
    end

    always @(negedge clk) begin
        if (done8) begin
            if (q8.size() == 0) begin
                tests++; fails++;
                $display("FAIL w8_unexpected_done out=%0h at cycle %0d, required no done", out8, cyc);
            end else begin
                e8 = q8.pop_front();
                chk("w8_out", out8, e8[7:0]); chk("w8_cout", cout8, e8[9]); chk("w8_ovf", ovf8, e8[8]);
                chk("w8_latency", cyc, e8[25:10]);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_zero("d1", {4'b0, out1}, cout1, ovf1, busy1, done1);
        chk_zero("d2", {4'b0, out2}, cout2, ovf2, busy2, done2);
        chk_zero("d4", {4'b0, out4}, cout4, ovf4, busy4, done4);
        chk_zero("w8", out8, cout8, ovf8, busy8, done8);
        rst = 1'b0;

        // Hand-computed WIDTH=4 vectors: {cout, ovf, out}
        w4_issue(4'd7, 4'd9, 1'b0, 1'b0, {1'b1, 1'b0, 8'h00});
        w4_issue(4'd5, 4'd3, 1'b0, 1'b0, {1'b0, 1'b1, 8'h08});
        w4_issue(4'd3, 4'd5, 1'b1, 1'b1, {1'b0, 1'b0, 8'h0E});
        w4_issue(4'd0, 4'd0, 1'b0, 1'b1, {1'b1, 1'b0, 8'h00});
        w4_issue(4'd8, 4'd1, 1'b0, 1'b1, {1'b1, 1'b1, 8'h07});
        w4_issue(4'hF, 4'hF, 1'b1, 1'b0, {1'b1, 1'b0, 8'h0F});

        // Hand-computed WIDTH=8, DIGIT=4 vectors
        w8_issue(8'hFF, 8'h01, 1'b1, 1'b0, {1'b1, 1'b0, 8'h01});
        w8_issue(8'h7F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b1, 8'h80});
        w8_issue(8'h10, 8'h20, 1'b1, 1'b1, {1'b0, 1'b0, 8'hF0});
        w8_issue(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
        w8_issue(8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10});

        // start held high, operands changing every cycle: an instance with N
        // slices accepts every N+1 edges
        repeat (6) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk) #1;
            x = 4'(k * 3 + 1); y = 4'(k * 5 + 2); cin = 1'(k); sub = 1'(k >> 1); start = 1'b1;
            push4(cyc, ref4(x, y, cin, sub), (k % 5) == 0, (k % 3) == 0, (k % 2) == 0);
        end
        @(posedge clk) #1;
        start = 1'b0;
        repeat (8) @(posedge clk);

        // Reset during the 2nd RUN cycle: only the single-slice instance finishes first
        @(posedge clk) #1;
        x = 4'd6; y = 4'd5; cin = 1'b0; sub = 1'b0; start = 1'b1;
        push4(cyc, {1'b0, 1'b1, 8'h0B}, 1'b0, 1'b0, 1'b1);
        @(posedge clk) #1;
        start = 1'b0;
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        chk_zero("d1", {4'b0, out1}, cout1, ovf1, busy1, done1);
        chk_zero("d2", {4'b0, out2}, cout2, ovf2, busy2, done2);
        chk_zero("d4", {4'b0, out4}, cout4, ovf4, busy4, done4);
        rst = 1'b0;
        x = 4'd1; y = 4'd1; cin = 1'b0; sub = 1'b0; start = 1'b1;
        push4(cyc, {1'b0, 1'b0, 8'h02}, 1'b1, 1'b1, 1'b1);
        @(posedge clk) #1;
        start = 1'b0;
        repeat (6) @(posedge clk);

        // Exhaustive WIDTH=4 sweep against the bench's reference arithmetic
        for (int xi = 0; xi < 16; xi++)
            for (int yi = 0; yi < 16; yi++)
                for (int m = 0; m < 4; m++)
                    w4_issue(4'(xi), 4'(yi), m[0], m[1], ref4(4'(xi), 4'(yi), m[0], m[1]));

        repeat (8) @(posedge clk);
        #1;
        chk("d1_queue_drained", q1.size(), 0);
        chk("d2_queue_drained", q2.size(), 0);
        chk("d4_queue_drained", q4.size(), 0);
        chk("w8_queue_drained", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
